accel_thread_arbiter: RTL and testbench
=======================================

// Module: accel_thread_arbiter
// PURPOSE
//  Upstream/downstream companion of the IP-match accelerator: accepts one source-IP lookup per thread,
//  round-robin arbitrates pending requests onto the single accelerator issue port, tracks in-flight
//  lookups, and routes each returned action/match back to the originating thread. Sits between the
//  per-thread cores and the accelerator; the flow-table setup path bypasses it.
// PARAMETERS
//  NUM_THREADS  4  number of requesting threads (one slot each)
//  THREAD_BITS  2  log2(NUM_THREADS); width of thread id on accelerator side
//  NUM_ACTIONS  4  width of action vector returned by accelerator
// PORTS
//  clk             in   1                 clock
//  reset           in   1                 reset, synchronous, active-high
//  req_valid       in   NUM_THREADS       per-thread lookup request strobe
//  req_ip          in   32*NUM_THREADS    per-thread source IP, thread t at [32t+31:32t]
//  req_ready       out  NUM_THREADS       slot t idle, can accept a request
//  setup_busy      in   1                 flow-table write in progress; blocks issue
//  acc_start       out  1                 one-cycle issue strobe to accelerator start
//  acc_ip          out  32                IP to accelerator, valid with acc_start
//  acc_thread_id   out  THREAD_BITS       granted thread, valid with acc_start
//  acc_done        in   1                 accelerator result strobe
//  acc_thread_id_r in   THREAD_BITS       thread id returned with acc_done
//  acc_action      in   NUM_ACTIONS       action, valid with acc_done
//  acc_match       in   1                 match flag, valid with acc_done
//  rsp_valid       out  NUM_THREADS       one-hot one-cycle response strobe
//  rsp_action      out  NUM_ACTIONS       action, valid with any rsp_valid bit
//  rsp_match       out  1                 match flag, valid with any rsp_valid bit
//  inflight_cnt    out  THREAD_BITS+1     lookups issued, not yet returned
//  err_unexpected  out  1                 sticky: acc_done for a thread not IN_FLIGHT
// BEHAVIOUR
//  Reset: all slots IDLE, rr pointer 0; all outputs 0 except req_ready = all ones.
//  Per-slot FSM: IDLE -(req_valid&req_ready)-> PENDING (latch req_ip) -(granted)-> IN_FLIGHT
//   -(acc_done & acc_thread_id_r==t)-> IDLE. req_ready[t] = (slot t == IDLE), combinational from state.
//  req_valid while slot not IDLE is ignored (no queueing, no error).
//  Arbiter: each cycle with !setup_busy and >=1 PENDING slot, grant first PENDING slot at or after
//   rr pointer (wrap NUM_THREADS-1 -> 0); pointer <= grant+1 mod NUM_THREADS. No grant: pointer holds.
//  Issue is registered: grant in cycle n -> acc_start=1, acc_ip, acc_thread_id in cycle n+1; max one
//   issue per cycle; acc_start deasserts next cycle unless another grant.
//  setup_busy=1: no grants, PENDING slots hold; an issue already registered still goes out.
//  Response: acc_done in cycle m -> rsp_valid[acc_thread_id_r]=1, rsp_action, rsp_match in cycle m+1
//   (registered); slot returns IDLE at end of cycle m, req_ready visible in cycle m+1.
//  Accelerator returns results in issue order, fixed 2 cycles after acc_start; arbiter does not
//   depend on the latency, only on the returned thread id.
//  acc_done for a slot not IN_FLIGHT: err_unexpected<=1 (sticky until reset), no rsp_valid, no state change.
//  inflight_cnt: +1 on grant, -1 on valid response; both same cycle -> unchanged. Never exceeds NUM_THREADS.
//  Same thread: response and new req_valid same cycle -> request ignored (ready was 0).
//  Reset mid-operation: slots cleared, pending/in-flight lookups dropped; accelerator shares reset so
//   no stale acc_done follows.
// STRUCTURE
//  Shared package: slot state encoding (IDLE=2'd0, PENDING=2'd1, IN_FLIGHT=2'd2), IP width 32.
//  One sub-module natural: rr_arbiter (NUM_THREADS request vector, pointer in, one-hot grant + index out).
//  Top holds slot FSMs, IP latches, issue/response registers, counters.
// TESTING
//  T1 single: req_valid[2], ip=0x0A000001, acc_done id=2 action=4'b0100 match=1 two cycles after
//     acc_start -> rsp_valid=4'b0100, rsp_action=4'b0100, rsp_match=1; req_ready[2] low until then.
//  T2 fairness: all 4 threads request same cycle, pointer 0 -> acc_thread_id 0,1,2,3 on consecutive
//     cycles; re-request of thread 0 after return does not precede a still-pending thread 1..3.
//  T3 setup_busy held 5 cycles with 2 PENDING -> no acc_start during hold; issues resume cycle after drop.
//  T4 acc_done id=1 while slot 1 IDLE -> err_unexpected=1 stays set, rsp_valid=0, inflight_cnt unchanged.
//  T5 reset asserted with 3 in flight -> next cycle inflight_cnt=0, req_ready=4'b1111, acc_start=0.
//  T6 grant and response same cycle -> inflight_cnt unchanged; counter never exceeds 4 under random load.

Source files
------------

// File: rtl/accel_thread_arbiter_pkg.sv
// Shared types for the IP-match accelerator thread arbiter: slot state encoding and IP width.
package accel_thread_arbiter_pkg;

  localparam int IP_W = 32;

  typedef enum logic [1:0] {
    SLOT_IDLE      = 2'd0,
    SLOT_PENDING   = 2'd1,
    SLOT_IN_FLIGHT = 2'd2
  } slot_state_e;

endpackage

// File: rtl/accel_thread_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N-1.
module accel_thread_arbiter_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  int cand;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    // Scan farthest-first so the candidate nearest the pointer overwrites the rest.
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_BITS'(cand);
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/accel_thread_arbiter.sv
// Per-thread lookup slots, round-robin issue onto the single accelerator port,
// and routing of returned action/match back to the originating thread.
module accel_thread_arbiter
  import accel_thread_arbiter_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int THREAD_BITS = 2,
  parameter int NUM_ACTIONS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_THREADS-1:0]      req_valid,
  input  logic [32*NUM_THREADS-1:0]   req_ip,
  output logic [NUM_THREADS-1:0]      req_ready,
  input  logic                        setup_busy,
  output logic                        acc_start,
  output logic [31:0]                 acc_ip,
  output logic [THREAD_BITS-1:0]      acc_thread_id,
  input  logic                        acc_done,
  input  logic [THREAD_BITS-1:0]      acc_thread_id_r,
  input  logic [NUM_ACTIONS-1:0]      acc_action,
  input  logic                        acc_match,
  output logic [NUM_THREADS-1:0]      rsp_valid,
  output logic [NUM_ACTIONS-1:0]      rsp_action,
  output logic                        rsp_match,
  output logic [THREAD_BITS:0]        inflight_cnt,
  output logic                        err_unexpected
);

  localparam logic [THREAD_BITS-1:0] PTR_ONE  = THREAD_BITS'(1);
  localparam logic [THREAD_BITS-1:0] PTR_LAST = THREAD_BITS'(NUM_THREADS - 1);
  localparam logic [THREAD_BITS:0]   CNT_ONE  = (THREAD_BITS + 1)'(1);

  logic [NUM_THREADS-1:0]      pending;
  logic [NUM_THREADS-1:0]      in_flight;
  logic [NUM_THREADS-1:0]      grant;
  logic [NUM_THREADS-1:0]      done_onehot;
  logic [THREAD_BITS-1:0]      grant_idx;
  logic                        grant_valid;
  logic                        done_hit;
  logic [IP_W*NUM_THREADS-1:0] slot_ip;

  logic [THREAD_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                   acc_start_q, acc_start_d;
  logic [IP_W-1:0]        acc_ip_q, acc_ip_d;
  logic [THREAD_BITS-1:0] acc_tid_q, acc_tid_d;
  logic [NUM_THREADS-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_ACTIONS-1:0] rsp_action_q, rsp_action_d;
  logic                   rsp_match_q, rsp_match_d;
  logic [THREAD_BITS:0]   inflight_q, inflight_d;
  logic                   err_q, err_d;

  // A result only counts if its thread is actually waiting on one.
  assign done_hit    = acc_done & in_flight[acc_thread_id_r];
  assign done_onehot = done_hit ? (NUM_THREADS'(1) << acc_thread_id_r) : '0;

  accel_thread_arbiter_rr_arbiter #(
    .N        (NUM_THREADS),
    .IDX_BITS (THREAD_BITS)
  ) u_rr (
    .req         (setup_busy ? '0 : pending),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_slot
      slot_state_e     st_q, st_d;
      logic [IP_W-1:0] ip_q, ip_d;

      always_comb begin
        st_d = st_q;
        ip_d = ip_q;
        case (st_q)
          SLOT_IDLE: begin
            if (req_valid[gi]) begin
              st_d = SLOT_PENDING;
              ip_d = req_ip[gi*IP_W +: IP_W];
            end
          end
          SLOT_PENDING:   if (grant[gi]) st_d = SLOT_IN_FLIGHT;
          SLOT_IN_FLIGHT: if (done_onehot[gi]) st_d = SLOT_IDLE;
          default:        st_d = SLOT_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          st_q <= SLOT_IDLE;
          ip_q <= '0;
        end else begin
          st_q <= st_d;
          ip_q <= ip_d;
        end
      end

      assign req_ready[gi]             = (st_q == SLOT_IDLE);
      assign pending[gi]               = (st_q == SLOT_PENDING);
      assign in_flight[gi]             = (st_q == SLOT_IN_FLIGHT);
      assign slot_ip[gi*IP_W +: IP_W]  = ip_q;
    end
  endgenerate

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    acc_start_d  = grant_valid;
    acc_ip_d     = acc_ip_q;
    acc_tid_d    = acc_tid_q;
    rsp_valid_d  = done_onehot;
    rsp_action_d = rsp_action_q;
    rsp_match_d  = rsp_match_q;
    inflight_d   = inflight_q;
    err_d        = err_q | (acc_done & ~done_hit);

    if (grant_valid) begin
      rr_ptr_d  = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_ONE;
      acc_ip_d  = slot_ip[grant_idx*IP_W +: IP_W];
      acc_tid_d = grant_idx;
    end
    if (done_hit) begin
      rsp_action_d = acc_action;
      rsp_match_d  = acc_match;
    end
    case ({grant_valid, done_hit})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      acc_start_q  <= 1'b0;
      acc_ip_q     <= '0;
      acc_tid_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_action_q <= '0;
      rsp_match_q  <= 1'b0;
      inflight_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      acc_start_q  <= acc_start_d;
      acc_ip_q     <= acc_ip_d;
      acc_tid_q    <= acc_tid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_action_q <= rsp_action_d;
      rsp_match_q  <= rsp_match_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
    end
  end

  assign acc_start      = acc_start_q;
  assign acc_ip         = acc_ip_q;
  assign acc_thread_id  = acc_tid_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_action     = rsp_action_q;
  assign rsp_match      = rsp_match_q;
  assign inflight_cnt   = inflight_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_accel_thread_arbiter.sv
// Directed bench for accel_thread_arbiter with a fixed-latency accelerator stand-in
// (action = one-hot of thread id, match = IP bit 0, result 2 cycles after acc_start).
module tb_accel_thread_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_ip;
  logic [3:0]   req_ready;
  logic         setup_busy;
  logic         acc_start;
  logic [31:0]  acc_ip;
  logic [1:0]   acc_thread_id;
  logic         acc_done;
  logic [1:0]   acc_thread_id_r;
  logic [3:0]   acc_action;
  logic         acc_match;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_action;
  logic         rsp_match;
  logic [2:0]   inflight_cnt;
  logic         err_unexpected;

  logic        model_en;
  logic        man_done;
  logic [1:0]  man_id;
  logic [3:0]  man_action;
  logic        man_match;
  logic        m_v1, m_v2;
  logic [1:0]  m_id1, m_id2;
  logic [31:0] m_ip1, m_ip2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_thread_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ip          (req_ip),
    .req_ready       (req_ready),
    .setup_busy      (setup_busy),
    .acc_start       (acc_start),
    .acc_ip          (acc_ip),
    .acc_thread_id   (acc_thread_id),
    .acc_done        (acc_done),
    .acc_thread_id_r (acc_thread_id_r),
    .acc_action      (acc_action),
    .acc_match       (acc_match),
    .rsp_valid       (rsp_valid),
    .rsp_action      (rsp_action),
    .rsp_match       (rsp_match),
    .inflight_cnt    (inflight_cnt),
    .err_unexpected  (err_unexpected)
  );

  always @(posedge clk) begin
    if (reset) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0;
      m_id1 <= '0;  m_id2 <= '0;
      m_ip1 <= '0;  m_ip2 <= '0;
    end else begin
      m_v1 <= acc_start; m_id1 <= acc_thread_id; m_ip1 <= acc_ip;
      m_v2 <= m_v1;      m_id2 <= m_id1;         m_ip2 <= m_ip1;
    end
  end

  assign acc_done        = model_en ? m_v2 : man_done;
  assign acc_thread_id_r = model_en ? m_id2 : man_id;
  assign acc_action      = model_en ? (4'b0001 << m_id2) : man_action;
  assign acc_match       = model_en ? m_ip2[0] : man_match;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1'b1; req_valid = '0; req_ip = '0; setup_busy = 1'b0;
    model_en = 1'b1; man_done = 1'b0; man_id = '0; man_action = '0; man_match = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task test_reset;
    do_reset;
    n_cmp++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
    n_cmp++; if (acc_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", acc_start); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp: got %b want 0000", rsp_valid); end
    n_cmp++; if (inflight_cnt !== 3'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", inflight_cnt); end
    n_cmp++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_unexpected); end
    n_cmp++; if (acc_ip !== 32'h0) begin n_err++; $display("FAIL reset_acc_ip: got %h want 0", acc_ip); end
    $display("test_reset done");
  endtask

  task test_single;
    do_reset;
    req_valid = 4'b0100; req_ip[95:64] = 32'h0A000001;
    tick; req_valid = '0;
    n_cmp++; if (req_ready !== 4'b1011) begin n_err++; $display("FAIL t1_ready_pending: got %b want 1011", req_ready); end
    n_cmp++; if (acc_start !== 1'b0) begin n_err++; $display("FAIL t1_no_early_start: got %b want 0", acc_start); end
    tick;
    n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'd2 || acc_ip !== 32'h0A000001) begin
      n_err++; $display("FAIL t1_issue: got start=%b id=%0d ip=%h want 1/2/0a000001", acc_start, acc_thread_id, acc_ip); end
    n_cmp++; if (inflight_cnt !== 3'd1) begin n_err++; $display("FAIL t1_inflight: got %0d want 1", inflight_cnt); end
    tick;
    n_cmp++; if (acc_start !== 1'b0) begin n_err++; $display("FAIL t1_start_pulse: got %b want 0", acc_start); end
    tick;
    n_cmp++; if (req_ready !== 4'b1011 || rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL t1_wait: got ready=%b rsp=%b want 1011/0000", req_ready, rsp_valid); end
    tick;
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_action !== 4'b0100 || rsp_match !== 1'b1) begin
      n_err++; $display("FAIL t1_rsp: got v=%b a=%b m=%b want 0100/0100/1", rsp_valid, rsp_action, rsp_match); end
    n_cmp++; if (req_ready !== 4'b1111 || inflight_cnt !== 3'd0) begin
      n_err++; $display("FAIL t1_after: got ready=%b cnt=%0d want 1111/0", req_ready, inflight_cnt); end
    tick;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL t1_rsp_pulse: got %b want 0000", rsp_valid); end
    $display("test_single done");
  endtask

  task test_fairness;
    do_reset;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_ip[32*k +: 32] = 32'hC0A80000 + 32'(k);
    tick; req_valid = '0;
    tick;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'(k) || acc_ip !== 32'hC0A80000 + 32'(k)) begin
        n_err++; $display("FAIL t2_issue%0d: got start=%b id=%0d ip=%h want 1/%0d", k, acc_start, acc_thread_id, acc_ip, k); end
      // grant of thread 3 and response of thread 0 land on the same edge: count stays 3
      n_cmp++; if (inflight_cnt !== 3'((k == 3) ? 3 : k + 1)) begin
        n_err++; $display("FAIL t2_inflight%0d: got %0d want %0d", k, inflight_cnt, (k == 3) ? 3 : k + 1); end
      n_cmp++; if (rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL t2_rsp_early%0d: got %b", k, rsp_valid); end
      tick;
    end
    for (int j = 1; j < 4; j++) begin
      n_cmp++; if (rsp_valid !== (4'b0001 << j) || rsp_action !== (4'b0001 << j) || rsp_match !== j[0]) begin
        n_err++; $display("FAIL t2_rsp%0d: got v=%b a=%b m=%b", j, rsp_valid, rsp_action, rsp_match); end
      n_cmp++; if (inflight_cnt !== 3'(3 - j) || acc_start !== 1'b0) begin
        n_err++; $display("FAIL t2_drain%0d: got cnt=%0d start=%b want %0d/0", j, inflight_cnt, acc_start, 3 - j); end
      tick;
    end
    // Re-request of thread 0 while 1..3 are held pending must queue behind them.
    do_reset;
    req_valid = 4'b1111;
    tick; req_valid = '0;
    tick; setup_busy = 1'b1;
    n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'd0) begin
      n_err++; $display("FAIL t2b_first: got start=%b id=%0d want 1/0", acc_start, acc_thread_id); end
    tick; tick; tick;
    n_cmp++; if (rsp_valid !== 4'b0001 || req_ready !== 4'b0001) begin
      n_err++; $display("FAIL t2b_return: got rsp=%b ready=%b want 0001/0001", rsp_valid, req_ready); end
    req_valid = 4'b0001;
    tick; req_valid = '0; setup_busy = 1'b0;
    n_cmp++; if (req_ready !== 4'b0000 || acc_start !== 1'b0) begin
      n_err++; $display("FAIL t2b_hold: got ready=%b start=%b want 0000/0", req_ready, acc_start); end
    tick;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'(k + 1)) begin
        n_err++; $display("FAIL t2b_order%0d: got start=%b id=%0d want 1/%0d", k, acc_start, acc_thread_id, (k + 1) % 4); end
      tick;
    end
    $display("test_fairness done");
  endtask

  task test_setup_busy;
    do_reset;
    setup_busy = 1'b1; req_valid = 4'b0101;
    req_ip[31:0] = 32'h11111110; req_ip[95:64] = 32'h22222221;
    tick; req_valid = '0;
    for (int i = 1; i <= 5; i++) begin
      n_cmp++; if (acc_start !== 1'b0 || req_ready !== 4'b1010) begin
        n_err++; $display("FAIL t3_hold%0d: got start=%b ready=%b want 0/1010", i, acc_start, req_ready); end
      if (i == 5) setup_busy = 1'b0;
      tick;
    end
    n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'd0 || acc_ip !== 32'h11111110) begin
      n_err++; $display("FAIL t3_resume0: got start=%b id=%0d ip=%h want 1/0/11111110", acc_start, acc_thread_id, acc_ip); end
    tick;
    n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'd2 || acc_ip !== 32'h22222221) begin
      n_err++; $display("FAIL t3_resume2: got start=%b id=%0d ip=%h want 1/2/22222221", acc_start, acc_thread_id, acc_ip); end
    $display("test_setup_busy done");
  endtask

  task test_unexpected;
    do_reset;
    model_en = 1'b0;
    man_done = 1'b1; man_id = 2'd1; man_action = 4'b1111; man_match = 1'b1;
    tick; man_done = 1'b0;
    n_cmp++; if (err_unexpected !== 1'b1 || rsp_valid !== 4'b0000 || inflight_cnt !== 3'd0) begin
      n_err++; $display("FAIL t4_idle: got err=%b rsp=%b cnt=%0d want 1/0000/0", err_unexpected, rsp_valid, inflight_cnt); end
    tick; tick;
    n_cmp++; if (err_unexpected !== 1'b1 || req_ready !== 4'b1111) begin
      n_err++; $display("FAIL t4_sticky: got err=%b ready=%b want 1/1111", err_unexpected, req_ready); end
    setup_busy = 1'b1; req_valid = 4'b1000; req_ip[127:96] = 32'hDEADBEEF;
    tick; req_valid = '0;
    man_done = 1'b1; man_id = 2'd3;
    tick; man_done = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0111) begin
      n_err++; $display("FAIL t4_pending: got rsp=%b ready=%b want 0000/0111", rsp_valid, req_ready); end
    setup_busy = 1'b0;
    tick;
    n_cmp++; if (acc_start !== 1'b1 || acc_thread_id !== 2'd3 || acc_ip !== 32'hDEADBEEF || inflight_cnt !== 3'd1) begin
      n_err++; $display("FAIL t4_kept: got start=%b id=%0d ip=%h cnt=%0d", acc_start, acc_thread_id, acc_ip, inflight_cnt); end
    $display("test_unexpected done");
  endtask

  task test_mid_reset;
    do_reset;
    req_valid = 4'b1111;
    tick; req_valid = '0;
    tick; tick; tick;
    n_cmp++; if (inflight_cnt !== 3'd3) begin n_err++; $display("FAIL t5_before: got %0d want 3", inflight_cnt); end
    reset = 1'b1;
    tick;
    n_cmp++; if (inflight_cnt !== 3'd0 || req_ready !== 4'b1111 || acc_start !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL t5_after: got cnt=%0d ready=%b start=%b rsp=%b", inflight_cnt, req_ready, acc_start, rsp_valid); end
    reset = 1'b0;
    tick;
    n_cmp++; if (acc_start !== 1'b0 || acc_done !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL t5_quiet: got start=%b done=%b rsp=%b", acc_start, acc_done, rsp_valid); end
    $display("test_mid_reset done");
  endtask

  task test_random_load;
    int starts;
    int rsps;
    int waited;
    do_reset;
    starts = 0; rsps = 0;
    for (int c = 0; c < 200; c++) begin
      req_valid = 4'($urandom);
      for (int k = 0; k < 4; k++) req_ip[32*k +: 32] = $urandom;
      setup_busy = ($urandom_range(0, 3) == 0);
      tick;
      starts += int'(acc_start);
      rsps   += int'(rsp_valid != 4'b0000);
      n_cmp++; if (int'(inflight_cnt) !== starts - rsps || inflight_cnt > 3'd4) begin
        n_err++; $display("FAIL t6_count c%0d: got %0d want %0d", c, inflight_cnt, starts - rsps); end
      n_cmp++; if (!$onehot0(rsp_valid) || (rsp_valid != 4'b0000 && rsp_action !== rsp_valid)) begin
        n_err++; $display("FAIL t6_route c%0d: got v=%b a=%b", c, rsp_valid, rsp_action); end
    end
    req_valid = '0; setup_busy = 1'b0;
    waited = 0;
    while ((inflight_cnt != 3'd0 || req_ready != 4'b1111) && waited < 30) begin
      tick; waited++;
    end
    n_cmp++; if (inflight_cnt !== 3'd0 || req_ready !== 4'b1111) begin
      n_err++; $display("FAIL t6_drain: got cnt=%0d ready=%b want 0/1111", inflight_cnt, req_ready); end
    $display("test_random_load done");
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_setup_busy;
    test_unexpected;
    test_mid_reset;
    test_random_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1);
  end

endmodule
